// File: rtl/neuron_trace_plotter_pkg.sv
// Shared defaults and arithmetic helpers for the multi-lane LIF trace plotter.
package neuron_pkg;

   localparam int COORD_W_DEF = 10;
   localparam int V_W_DEF     = 10;

   function automatic int sat_add(input int a, input int b, input int max_v);
      int s;
      s = a + b;
      return (s > max_v) ? max_v : s;
   endfunction

   function automatic int lane_baseline(input int lane, input int base, input int pitch);
      return base - lane * pitch;
   endfunction

endpackage

// File: rtl/neuron_trace_plotter_if.sv
// Spike, scan and display signals of the plotter, grouped with master/slave views.
interface neuron_trace_plotter_if
   import neuron_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int COORD_W = COORD_W_DEF
);
   logic [NUM_CH-1:0]  i_Spike_In;
   logic               i_Freeze;
   logic [COORD_W-1:0] i_Col_Count_Div;
   logic [COORD_W-1:0] i_Row_Count_Div;
   logic               o_Pixel;
   logic [NUM_CH-1:0]  o_Pixel_Ch;
   logic [NUM_CH-1:0]  o_Spike_Out;
   logic               o_Tick;
   logic [COORD_W-1:0] o_Trace_X;

   modport master (
      output i_Spike_In, i_Freeze, i_Col_Count_Div, i_Row_Count_Div,
      input  o_Pixel, o_Pixel_Ch, o_Spike_Out, o_Tick, o_Trace_X
   );

   modport slave (
      input  i_Spike_In, i_Freeze, i_Col_Count_Div, i_Row_Count_Div,
      output o_Pixel, o_Pixel_Ch, o_Spike_Out, o_Tick, o_Trace_X
   );
endinterface

// File: rtl/neuron_trace_plotter_lif_lane.sv
// One LIF lane: spike latch, membrane/refractory state, trace history and pixel hit test.
module lif_lane
   import neuron_pkg::*;
#(
   parameter int LANE       = 0,
   parameter int HIST_DEPTH = 32,
   parameter int COORD_W    = COORD_W_DEF,
   parameter int V_W        = V_W_DEF,
   parameter int LANE_BASE  = 440,
   parameter int LANE_PITCH = 120,
   parameter int THRESHOLD  = 100,
   parameter int PSP_WEIGHT = 40,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRACT    = 4
) (
   input  logic               i_Clk,
   input  logic               i_Rst_n,
   input  logic               i_Tick,
   input  logic               i_Freeze,
   input  logic               i_Spike,
   input  logic [COORD_W-1:0] i_X,
   input  logic [COORD_W-1:0] i_Col,
   input  logic [COORD_W-1:0] i_Row,
   output logic               o_Spike,
   output logic               o_Hit
);
   localparam int BASE    = lane_baseline(LANE, LANE_BASE, LANE_PITCH);
   localparam int THR_ROW = BASE - THRESHOLD;
   localparam int V_MAX   = (1 << V_W) - 1;
   localparam int PTR_W   = $clog2(HIST_DEPTH);
   localparam int REF_W   = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);

   logic                  pend_q, pend_d;
   logic [V_W-1:0]        v_q, v_d;
   logic [REF_W-1:0]      refr_q, refr_d;
   logic                  spike_q, spike_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [HIST_DEPTH-1:0] hv_q, hv_d;
   logic [COORD_W-1:0]    hx_q [HIST_DEPTH];
   logic [COORD_W-1:0]    hy_q [HIST_DEPTH];
   logic [COORD_W-1:0]    y_s;
   logic                  hit_q, hit_d;
   int                    y_int;
   int                    n_int;

   // screen row of the live point; potentials above the baseline pin to the top row
   always_comb begin
      y_int = BASE - int'(v_q);
      y_s   = (y_int < 0) ? '0 : COORD_W'(y_int);
   end

   // spike latch and membrane integration with leak, saturation and refractory hold
   always_comb begin
      pend_d  = pend_q;
      v_d     = v_q;
      refr_d  = refr_q;
      spike_d = 1'b0;
      n_int   = sat_add(int'(v_q) - int'(v_q >> LEAK_SHIFT),
                        (pend_q | i_Spike) ? PSP_WEIGHT : 0, V_MAX);
      if (i_Tick) begin
         pend_d = 1'b0;
         if (refr_q != '0) begin
            v_d    = '0;
            refr_d = refr_q - REF_W'(1);
         end else if (n_int >= THRESHOLD) begin
            v_d     = '0;
            refr_d  = REF_W'(REFRACT);
            spike_d = 1'b1;
         end else begin
            v_d = V_W'(n_int);
         end
      end else if (!i_Freeze) begin
         pend_d = pend_q | i_Spike;
      end else begin
         pend_d = pend_q;
      end
   end

   // history ring bookkeeping; the oldest slot is overwritten once full
   always_comb begin
      ptr_d = ptr_q;
      hv_d  = hv_q;
      if (i_Tick) begin
         hv_d[ptr_q] = 1'b1;
         ptr_d       = ptr_q + PTR_W'(1);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // lane hit: live point, any stored point, or the dashed threshold line
   always_comb begin
      hit_d = (i_Col == i_X) && (i_Row == y_s);
      for (int i = 0; i < HIST_DEPTH; i++) begin
         hit_d = hit_d | (hv_q[i] && (hx_q[i] == i_Col) && (hy_q[i] == i_Row));
      end
      hit_d = hit_d | ((i_Row == COORD_W'(THR_ROW)) && !i_Col[1]);
   end

   // lane state registers
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         pend_q  <= 1'b0;
         v_q     <= '0;
         refr_q  <= '0;
         spike_q <= 1'b0;
         ptr_q   <= '0;
         hv_q    <= '0;
         hit_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         v_q     <= v_d;
         refr_q  <= refr_d;
         spike_q <= spike_d;
         ptr_q   <= ptr_d;
         hv_q    <= hv_d;
         hit_q   <= hit_d;
      end
   end

   // history payload; only the valid bits need clearing on reset
   always_ff @(posedge i_Clk) begin
      if (i_Tick) begin
         hx_q[ptr_q] <= i_X;
         hy_q[ptr_q] <= y_s;
      end
   end

   assign o_Spike = spike_q;
   assign o_Hit   = hit_q;

endmodule

// File: rtl/neuron_trace_plotter.sv
// Multi-lane LIF neuron with scrolling trace display: time-step and x counters plus lane array.
module neuron_trace_plotter
   import neuron_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int HIST_DEPTH = 32,
   parameter int COORD_W    = COORD_W_DEF,
   parameter int V_W        = V_W_DEF,
   parameter int TICK_DIV   = 250000,
   parameter int GAME_WIDTH = 640,
   parameter int LANE_BASE  = 440,
   parameter int LANE_PITCH = 120,
   parameter int THRESHOLD  = 100,
   parameter int PSP_WEIGHT = 40,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRACT    = 4
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_n,
   neuron_trace_plotter_if.slave bus
);
   localparam int CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic               tick_s;
   logic [NUM_CH-1:0]  hit_s;
   logic [NUM_CH-1:0]  spike_s;

   assign tick_s = !bus.i_Freeze && (cnt_q == CNT_W'(TICK_DIV - 1));

   // time-step divider and scrolling x position; both stall while frozen
   always_comb begin
      cnt_d = cnt_q;
      x_d   = x_q;
      if (tick_s) begin
         cnt_d = '0;
         x_d   = (x_q == COORD_W'(GAME_WIDTH - 1)) ? '0 : x_q + COORD_W'(1);
      end else if (!bus.i_Freeze) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // counter registers
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         cnt_q <= '0;
         x_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         x_q   <= x_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      lif_lane #(
         .LANE       (g),
         .HIST_DEPTH (HIST_DEPTH),
         .COORD_W    (COORD_W),
         .V_W        (V_W),
         .LANE_BASE  (LANE_BASE),
         .LANE_PITCH (LANE_PITCH),
         .THRESHOLD  (THRESHOLD),
         .PSP_WEIGHT (PSP_WEIGHT),
         .LEAK_SHIFT (LEAK_SHIFT),
         .REFRACT    (REFRACT)
      ) u_lane (
         .i_Clk    (i_Clk),
         .i_Rst_n  (i_Rst_n),
         .i_Tick   (tick_s),
         .i_Freeze (bus.i_Freeze),
         .i_Spike  (bus.i_Spike_In[g]),
         .i_X      (x_q),
         .i_Col    (bus.i_Col_Count_Div),
         .i_Row    (bus.i_Row_Count_Div),
         .o_Spike  (spike_s[g]),
         .o_Hit    (hit_s[g])
      );
   end

   assign bus.o_Tick      = tick_s;
   assign bus.o_Trace_X   = x_q;
   assign bus.o_Spike_Out = spike_s;
   assign bus.o_Pixel_Ch  = hit_s;
   assign bus.o_Pixel     = |hit_s;

endmodule

// File: tb/tb_neuron_trace_plotter.sv
// Randomized scoreboard bench for neuron_trace_plotter against a step-level LIF/trace model.
module tb_neuron_trace_plotter;
   import neuron_pkg::*;

   localparam int NUM_CH = 2;
   localparam int HD     = 32;
   localparam int CW     = 10;
   localparam int TD     = 4;
   localparam int GW     = 640;
   localparam int LB     = 440;
   localparam int LP     = 120;
   localparam int THR    = 100;
   localparam int W      = 40;
   localparam int LS     = 3;
   localparam int RF     = 4;
   localparam int VMAX   = 1023;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   neuron_trace_plotter_if #(.NUM_CH(NUM_CH), .COORD_W(CW)) bus ();

   neuron_trace_plotter #(
      .NUM_CH(NUM_CH), .HIST_DEPTH(HD), .COORD_W(CW), .V_W(10), .TICK_DIV(TD),
      .GAME_WIDTH(GW), .LANE_BASE(LB), .LANE_PITCH(LP), .THRESHOLD(THR),
      .PSP_WEIGHT(W), .LEAK_SHIFT(LS), .REFRACT(RF)
   ) dut (
      .i_Clk   (clk),
      .i_Rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic              tick;
      logic [NUM_CH-1:0] spk;
      logic              pix;
      logic [NUM_CH-1:0] pch;
      logic [CW-1:0]     x;
   } exp_t;

   typedef struct packed {
      logic [CW-1:0]             x;
      logic [NUM_CH-1:0][CW-1:0] y;
   } pt_t;

   exp_t sb_q[$];
   pt_t  hist[$];
   pt_t  evicted;
   bit   have_evicted;
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;
   int   fires_seen = 0;

   int                m_cnt, m_x;
   int                m_v[NUM_CH];
   int                m_refr[NUM_CH];
   bit                m_pend[NUM_CH];
   logic [NUM_CH-1:0] m_spk_r, m_pch_r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int base_of(input int k);
      return LB - k * LP;
   endfunction

   function automatic int y_of(input int k);
      int y;
      y = base_of(k) - m_v[k];
      return (y < 0) ? 0 : y;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_x = 0; m_spk_r = '0; m_pch_r = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         m_v[k] = 0; m_refr[k] = 0; m_pend[k] = 1'b0;
      end
      hist.delete();
      have_evicted = 1'b0;
   endtask

   // one clock of stimulus; the expected outputs for this cycle go to the scoreboard
   task automatic step(input logic [NUM_CH-1:0] spk, input logic frz,
                       input logic [CW-1:0] col, input logic [CW-1:0] row);
      exp_t e;
      pt_t  p;
      logic [NUM_CH-1:0] hits, fired;
      int n;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.i_Spike_In = spk; bus.i_Freeze = frz;
      bus.i_Col_Count_Div = col; bus.i_Row_Count_Div = row;
      e.tick = !frz && (m_cnt == TD - 1);
      e.spk  = m_spk_r;
      e.pch  = m_pch_r;
      e.pix  = |m_pch_r;
      e.x    = CW'(m_x);
      sb_q.push_back(e);
      mon_en = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
         hits[k] = ((int'(col) == m_x) && (int'(row) == y_of(k))) ||
                   ((int'(row) == base_of(k) - THR) && !col[1]);
         foreach (hist[i]) if (hist[i].x == col && hist[i].y[k] == row) hits[k] = 1'b1;
      end
      m_pch_r = hits;
      if (e.tick) begin
         p.x = CW'(m_x);
         for (int k = 0; k < NUM_CH; k++) p.y[k] = CW'(y_of(k));
         hist.push_back(p);
         if (hist.size() > HD) begin
            evicted = hist.pop_front();
            have_evicted = 1'b1;
         end
         fired = '0;
         for (int k = 0; k < NUM_CH; k++) begin
            if (m_refr[k] > 0) begin
               m_v[k] = 0; m_refr[k]--;
            end else begin
               n = m_v[k] - m_v[k] / (1 << LS) + ((m_pend[k] || spk[k]) ? W : 0);
               if (n > VMAX) n = VMAX;
               if (n >= THR) begin
                  m_v[k] = 0; m_refr[k] = RF; fired[k] = 1'b1;
               end else begin
                  m_v[k] = n;
               end
            end
            m_pend[k] = 1'b0;
         end
         m_spk_r = fired;
         m_cnt = 0;
         m_x = (m_x == GW - 1) ? 0 : m_x + 1;
      end else begin
         m_spk_r = '0;
         if (!frz) begin
            m_cnt++;
            for (int k = 0; k < NUM_CH; k++) m_pend[k] = m_pend[k] | spk[k];
         end
      end
   endtask

   task automatic pick_scan(output logic [CW-1:0] col, output logic [CW-1:0] row);
      int k, mode, i;
      k    = int'($urandom_range(0, NUM_CH - 1));
      mode = int'($urandom_range(0, 5));
      col  = CW'($urandom_range(0, GW - 1));
      row  = CW'($urandom_range(0, 479));
      case (mode)
         1: begin col = CW'(m_x); row = CW'(y_of(k)); end
         2: if (hist.size() > 0) begin
               i = int'($urandom_range(0, hist.size() - 1));
               col = hist[i].x; row = hist[i].y[k];
            end
         3: row = CW'(base_of(k) - THR);
         4: if (have_evicted) begin col = evicted.x; row = evicted.y[k]; end
         default: ;
      endcase
   endtask

   task automatic do_reset(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         mon_en = 1'b0;
         rst_n = 1'b0;
         bus.i_Spike_In = NUM_CH'($urandom);
         bus.i_Freeze = 1'b0;
         bus.i_Col_Count_Div = CW'($urandom_range(0, GW - 1));
         bus.i_Row_Count_Div = CW'(LB - THR);
         @(negedge clk);
         chk("rst_tick", 32'(bus.o_Tick), 32'd0);
         chk("rst_x", 32'(bus.o_Trace_X), 32'd0);
         chk("rst_spike", 32'(bus.o_Spike_Out), 32'd0);
         chk("rst_pixel", 32'(bus.o_Pixel), 32'd0);
         chk("rst_pixel_ch", 32'(bus.o_Pixel_Ch), 32'd0);
      end
      model_reset();
   endtask

   // monitor: pop one expected record per cycle and compare every output
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("tick", 32'(bus.o_Tick), 32'(e.tick));
            chk("spike_out", 32'(bus.o_Spike_Out), 32'(e.spk));
            chk("pixel", 32'(bus.o_Pixel), 32'(e.pix));
            chk("pixel_ch", 32'(bus.o_Pixel_Ch), 32'(e.pch));
            chk("trace_x", 32'(bus.o_Trace_X), 32'(e.x));
            if (e.spk != '0) fires_seen++;
         end
      end
   end

   initial begin
      logic [CW-1:0]     col, row;
      logic [NUM_CH-1:0] spk;
      logic              frz;
      int                frz_left;
      bus.i_Spike_In = '0; bus.i_Freeze = 1'b0;
      bus.i_Col_Count_Div = '0; bus.i_Row_Count_Div = '0;
      do_reset(3);

      // lane 0 gets exactly one spike per step, lane 1 only on the tick clock
      for (int c = 0; c < 60; c++) begin
         pick_scan(col, row);
         spk = {1'b0, 1'b0};
         if (m_cnt == 0) spk[0] = 1'b1;
         if (m_cnt == TD - 1) spk[1] = 1'b1;
         step(spk, 1'b0, col, row);
      end

      // a 20-clock freeze in the middle of a step
      step('0, 1'b0, '0, '0);
      for (int c = 0; c < 20; c++) begin
         pick_scan(col, row);
         step(NUM_CH'($urandom), 1'b1, col, row);
      end

      // long random run, enough steps to wrap x and overflow the history
      frz_left = 0;
      for (int c = 0; c < 3200; c++) begin
         pick_scan(col, row);
         spk = '0;
         for (int k = 0; k < NUM_CH; k++) spk[k] = ($urandom_range(0, 5) == 0);
         if (frz_left == 0 && $urandom_range(0, 199) == 0) frz_left = int'($urandom_range(1, 20));
         frz = (frz_left > 0);
         if (frz_left > 0) frz_left--;
         step(spk, frz, col, row);
      end

      do_reset(2);
      for (int c = 0; c < 200; c++) begin
         pick_scan(col, row);
         spk = '0;
         for (int k = 0; k < NUM_CH; k++) spk[k] = ($urandom_range(0, 3) == 0);
         step(spk, 1'b0, col, row);
      end

      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      if (fires_seen == 0) chk("any_fire", 32'd0, 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
